hack_cpu_mc: RTL and testbench

HACK_CPU_MC -- requirements
Module: hack_cpu_mc

---
 rtl/hack_cpu_mc.sv | 187 ++++++++++++++++++
 tb/tb_hack_cpu_mc.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hack_cpu_mc.sv
// hack_cpu_mc -- multi-cycle Hack CPU with request/ready instruction and data ports.
//
// Each instruction walks FETCH -> DECODE -> [LOAD] -> [STORE] -> COMMIT. The A, D and PC
// registers change only in COMMIT, so an access abandoned by reset leaves no trace. The
// ALU result is registered once, in DECODE or LOAD. STORE and COMMIT both use that value.
//
// Ports
//   clock, reset          rising-edge clock, asynchronous active-low reset
//   imem_req/addr         fetch request at PC; imem_ready/imem_rdata complete it
//   dmem_req/we/addr      data access at A; dmem_wdata is the registered ALU result
//   dmem_ready/rdata      access accept; rdata is the load data (M)
//   halted                core has stopped on the "@n; 0;JMP at n+1" idiom
//   retired               count of committed instructions, wraps
//
// Parameters: DATA_W >= 16 and ADDR_W <= DATA_W-1, so that A can hold a full address.

module hack_cpu_mc #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 15,
    parameter int CNT_W  = 32
) (
    input  logic              clock,
    input  logic              reset,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ready,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic              dmem_ready,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic              halted,
    output logic [CNT_W-1:0]  retired
);

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        LOAD   = 3'd2,
        STORE  = 3'd3,
        COMMIT = 3'd4,
        HALT   = 3'd5
    } state_t;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   a_q, a_d;
    logic [DATA_W-1:0]   d_q, d_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [DATA_W-1:0]   instr_q, instr_d;
    logic [DATA_W-1:0]   alu_q, alu_d;
    // Set when the last committed instruction was an A-instruction. A-instructions
    // never jump, so that instruction sits at PC-1.
    logic                prev_a_q, prev_a_d;
    logic [CNT_W-1:0]    retired_q, retired_d;

    // Instruction fields
    logic       is_c, a_bit, dst_a, dst_d, dst_m;
    logic [5:0] ctl;
    logic [2:0] jmp;

    assign is_c  = instr_q[DATA_W-1];
    assign a_bit = instr_q[12];
    assign ctl   = instr_q[11:6];
    assign dst_a = instr_q[5];
    assign dst_d = instr_q[4];
    assign dst_m = instr_q[3];
    assign jmp   = instr_q[2:0];

    function automatic logic [DATA_W-1:0] alu_f(input logic [DATA_W-1:0] x,
                                                input logic [DATA_W-1:0] y,
                                                input logic [5:0]        c);
        logic [DATA_W-1:0] xa, ya, o;
        xa = c[5] ? '0 : x;
        xa = c[4] ? ~xa : xa;
        ya = c[3] ? '0 : y;
        ya = c[2] ? ~ya : ya;
        o  = c[1] ? (xa + ya) : (xa & ya);
        return c[0] ? ~o : o;
    endfunction

    // y operand is M only while LOAD completes; DECODE evaluates the A-operand form.
    logic [DATA_W-1:0] alu_y, alu_out;
    assign alu_y   = (state_q == LOAD) ? dmem_rdata : a_q;
    assign alu_out = alu_f(d_q, alu_y, ctl);

    // Jump and halt decisions use the registered result seen in COMMIT.
    logic zr, ng, jump_taken, halt_hit;
    logic [ADDR_W-1:0] pc_inc, pc_prev;

    assign zr         = (alu_q == '0);
    assign ng         = alu_q[DATA_W-1];
    assign jump_taken = is_c & ((jmp[2] & ng) | (jmp[1] & zr) | (jmp[0] & ~ng & ~zr));
    assign pc_inc     = pc_q + ADDR_W'(1);
    assign pc_prev    = pc_q - ADDR_W'(1);
    assign halt_hit   = jump_taken & prev_a_q & (a_q[ADDR_W-1:0] == pc_prev);

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        d_d       = d_q;
        pc_d      = pc_q;
        instr_d   = instr_q;
        alu_d     = alu_q;
        prev_a_d  = prev_a_q;
        retired_d = retired_q;
        case (state_q)
            FETCH: begin
                if (imem_ready) begin
                    instr_d = imem_rdata;
                    state_d = DECODE;
                end
            end
            DECODE: begin
                if (!is_c) begin
                    state_d = COMMIT;
                end else if (a_bit) begin
                    state_d = LOAD;
                end else begin
                    alu_d   = alu_out;
                    state_d = dst_m ? STORE : COMMIT;
                end
            end
            LOAD: begin
                if (dmem_ready) begin
                    alu_d   = alu_out;
                    state_d = dst_m ? STORE : COMMIT;
                end
            end
            STORE: begin
                if (dmem_ready) state_d = COMMIT;
            end
            COMMIT: begin
                if (!is_c) begin
                    a_d      = {1'b0, instr_q[DATA_W-2:0]};
                    prev_a_d = 1'b1;
                end else begin
                    if (dst_a) a_d = alu_q;
                    if (dst_d) d_d = alu_q;
                    prev_a_d = 1'b0;
                end
                pc_d      = jump_taken ? a_q[ADDR_W-1:0] : pc_inc;
                retired_d = retired_q + CNT_W'(1);
                state_d   = halt_hit ? HALT : FETCH;
            end
            HALT: begin
                state_d = HALT;
            end
            default: state_d = FETCH;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= FETCH;
            a_q       <= '0;
            d_q       <= '0;
            pc_q      <= '0;
            instr_q   <= '0;
            alu_q     <= '0;
            prev_a_q  <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            d_q       <= d_d;
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            alu_q     <= alu_d;
            prev_a_q  <= prev_a_d;
            retired_q <= retired_d;
        end
    end

    // Requests are gated by reset so that they drop the moment reset asserts, even
    // though the state register already reads FETCH.
    assign imem_req   = reset & (state_q == FETCH);
    assign imem_addr  = pc_q;
    assign dmem_req   = reset & ((state_q == LOAD) | (state_q == STORE));
    assign dmem_we    = reset & (state_q == STORE);
    assign dmem_addr  = a_q[ADDR_W-1:0];
    assign dmem_wdata = alu_q;
    assign halted     = (state_q == HALT);
    assign retired    = retired_q;

endmodule

// File: tb/tb_hack_cpu_mc.sv
// Directed bench for hack_cpu_mc: a default 16-bit core driven from a small ROM/RAM
// model, plus a 32-bit/20-bit build for width and PC-wrap behaviour.

module tb_hack_cpu_mc;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- 16-bit DUT ----------------
    logic        rst16;
    logic        imem_req, imem_ready, dmem_req, dmem_we, dmem_ready, halted;
    logic [14:0] imem_addr, dmem_addr;
    logic [15:0] imem_rdata, dmem_rdata, dmem_wdata;
    logic [31:0] retired;

    logic [15:0] rom16 [0:31];
    logic        imem_rdy, dmem_rdy;

    assign imem_ready = imem_rdy;
    assign dmem_ready = dmem_rdy;
    assign imem_rdata = (imem_addr < 15'd32) ? rom16[imem_addr[4:0]] : 16'h0000;
    // Load data is a fixed function of the address: mem[a] = 7*a + 6.
    assign dmem_rdata = {1'b0, dmem_addr} * 16'd7 + 16'd6;

    hack_cpu_mc dut16 (
        .clock(clk), .reset(rst16),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata), .halted(halted), .retired(retired)
    );

    int          wr_cnt = 0;
    logic [14:0] w_addr;
    logic [15:0] w_data;
    int          f_cnt = 0;
    logic [14:0] f_hist [0:63];

    always @(posedge clk) begin
        if (dmem_req && dmem_we && dmem_ready) begin
            wr_cnt <= wr_cnt + 1;
            w_addr <= dmem_addr;
            w_data <= dmem_wdata;
        end
        if (imem_req && imem_ready) begin
            f_hist[f_cnt[5:0]] <= imem_addr;
            f_cnt <= f_cnt + 1;
        end
    end

    // ---------------- 32-bit DUT ----------------
    logic        rst32;
    logic        imem_req32, dmem_req32, dmem_we32, halted32;
    logic [19:0] imem_addr32, dmem_addr32;
    logic [31:0] imem_rdata32, dmem_wdata32, retired32;
    logic        rdy32 = 1'b1;
    logic [31:0] zero32 = 32'h0;

    always_comb begin
        case (imem_addr32)
            20'd0:     imem_rdata32 = 32'h7FFF_FFFF; // @0x7FFFFFFF
            20'd1:     imem_rdata32 = 32'h8000_0DD0; // D=A+1
            20'd2:     imem_rdata32 = 32'h0000_0009; // @9
            20'd3:     imem_rdata32 = 32'h8000_0308; // M=D
            20'd4:     imem_rdata32 = 32'h000F_FFFF; // @0xFFFFF
            20'd5:     imem_rdata32 = 32'h8000_0304; // D;JLT
            20'hFFFFF: imem_rdata32 = 32'h0000_0123; // @0x123
            default:   imem_rdata32 = 32'h0000_0000;
        endcase
    end

    hack_cpu_mc #(.DATA_W(32), .ADDR_W(20), .CNT_W(32)) dut32 (
        .clock(clk), .reset(rst32),
        .imem_req(imem_req32), .imem_addr(imem_addr32), .imem_ready(rdy32), .imem_rdata(imem_rdata32),
        .dmem_req(dmem_req32), .dmem_we(dmem_we32), .dmem_addr(dmem_addr32), .dmem_wdata(dmem_wdata32),
        .dmem_ready(rdy32), .dmem_rdata(zero32), .halted(halted32), .retired(retired32)
    );

    int          w32_cnt = 0;
    logic [19:0] w32_addr;
    logic [31:0] w32_data;
    int          f32_cnt = 0;
    logic [19:0] f32_hist [0:15];

    always @(posedge clk) begin
        if (dmem_req32 && dmem_we32) begin
            w32_cnt  <= w32_cnt + 1;
            w32_addr <= dmem_addr32;
            w32_data <= dmem_wdata32;
        end
        if (imem_req32) begin
            f32_hist[f32_cnt[3:0]] <= imem_addr32;
            f32_cnt <= f32_cnt + 1;
        end
    end

    // ---------------- checking ----------------
    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] ci(input logic a, input logic [5:0] c,
                                       input logic [2:0] d, input logic [2:0] j);
        return {3'b111, a, c, d, j};
    endfunction

    // Comp codes
    localparam logic [5:0] C_ZERO = 6'b101010, C_ONE = 6'b111111, C_NEG1 = 6'b111010,
                           C_D = 6'b001100, C_A = 6'b110000, C_DPA = 6'b000010,
                           C_AP1 = 6'b110111;

    task automatic hold_reset(input string tag);
        #2 rst16 = 1'b0;
        #1;
        chk({tag, "_rst_halted"}, halted, 0);
        chk({tag, "_rst_retired"}, retired, 0);
        chk({tag, "_rst_ireq"}, imem_req, 0);
        chk({tag, "_rst_dreq"}, dmem_req, 0);
        tick();
        tick();
        for (int i = 0; i < 32; i++) rom16[i] = 16'h0000;
    endtask

    task automatic release_reset(input string tag);
        @(negedge clk);
        rst16 = 1'b1;
        #1;
        chk({tag, "_rel_ireq"}, imem_req, 1);
        chk({tag, "_rel_iaddr"}, imem_addr, 0);
    endtask

    task automatic wait_halt(input string tag, input int budget);
        int k;
        k = 0;
        while (!halted && k < budget) begin
            tick();
            k++;
        end
        chk({tag, "_halt_reached"}, halted, 1);
    endtask

    int w0, f0;

    initial begin
        rst16    = 1'b0;
        rst32    = 1'b0;
        imem_rdy = 1'b1;
        dmem_rdy = 1'b1;

        // ---- run 1: zero-wait sum program, then the halt idiom at 7..8 ----
        hold_reset("r1");
        rom16[0] = 16'd2;
        rom16[1] = ci(1'b0, C_A, 3'b010, 3'b000);   // D=A
        rom16[2] = 16'd3;
        rom16[3] = ci(1'b0, C_DPA, 3'b010, 3'b000); // D=D+A
        rom16[4] = 16'd0;
        rom16[5] = ci(1'b0, C_D, 3'b001, 3'b000);   // M=D
        rom16[6] = 16'd0;
        rom16[7] = 16'd7;
        rom16[8] = ci(1'b0, C_ZERO, 3'b000, 3'b111); // 0;JMP
        w0 = wr_cnt;
        release_reset("r1");
        // Five 3-cycle instructions then M=D (fetch, decode, store, commit): the store
        // lands on edge 18 and the sixth retire on edge 19.
        repeat (18) tick();
        chk("r1_wr_count", wr_cnt - w0, 1);
        chk("r1_wr_addr", w_addr, 0);
        chk("r1_wr_data", w_data, 5);
        chk("r1_retired_e18", retired, 5);
        tick();
        chk("r1_retired_e19", retired, 6);
        repeat (9) tick();
        chk("r1_halted", halted, 1);
        chk("r1_retired_halt", retired, 9);
        repeat (5) tick();
        chk("r1_halt_ireq", imem_req, 0);
        chk("r1_halt_dreq", dmem_req, 0);
        chk("r1_halt_retired", retired, 9);
        chk("r1_halt_iaddr", imem_addr, 7);

        // ---- run 2: first fetch stalled for 4 cycles ----
        hold_reset("r2");
        rom16[0] = 16'd2;
        rom16[1] = ci(1'b0, C_A, 3'b010, 3'b000);
        rom16[2] = 16'd3;
        rom16[3] = ci(1'b0, C_DPA, 3'b010, 3'b000);
        rom16[4] = 16'd0;
        rom16[5] = ci(1'b0, C_D, 3'b001, 3'b000);
        rom16[6] = 16'd0;
        rom16[7] = 16'd7;
        rom16[8] = ci(1'b0, C_ZERO, 3'b000, 3'b111);
        imem_rdy = 1'b0;
        w0 = wr_cnt;
        release_reset("r2");
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("r2_stall_ireq", imem_req, 1);
            chk("r2_stall_iaddr", imem_addr, 0);
        end
        imem_rdy = 1'b1;
        repeat (19) tick();
        chk("r2_retired", retired, 6);
        chk("r2_wr_count", wr_cnt - w0, 1);
        chk("r2_wr_data", w_data, 5);

        // ---- run 3: conditional jumps on D = 0xFFFF and D = 0 ----
        hold_reset("r3");
        rom16[0]  = ci(1'b0, C_NEG1, 3'b010, 3'b000); // D=-1
        rom16[1]  = 16'd10;
        rom16[2]  = ci(1'b0, C_D, 3'b000, 3'b100);    // D;JLT  taken
        rom16[10] = ci(1'b0, C_ZERO, 3'b010, 3'b000); // D=0
        rom16[11] = ci(1'b0, C_D, 3'b000, 3'b001);    // D;JGT  not taken
        rom16[12] = 16'd20;
        rom16[13] = ci(1'b0, C_D, 3'b000, 3'b010);    // D;JEQ  taken
        rom16[20] = 16'd20;
        rom16[21] = ci(1'b0, C_ZERO, 3'b000, 3'b111); // halt
        f0 = f_cnt;
        release_reset("r3");
        wait_halt("r3", 200);
        begin
            logic [14:0] exp_pc [0:8];
            int base;
            exp_pc = '{15'd0, 15'd1, 15'd2, 15'd10, 15'd11, 15'd12, 15'd13, 15'd20, 15'd21};
            base = f0;
            chk("r3_fetch_count", f_cnt - f0, 9);
            for (int i = 0; i < 9; i++)
                chk($sformatf("r3_pc%0d", i), f_hist[(base + i) % 64], exp_pc[i]);
        end
        chk("r3_retired", retired, 9);

        // ---- run 4: LOAD with data wait states, then store D+A ----
        hold_reset("r4");
        rom16[0] = 16'd5;
        rom16[1] = ci(1'b1, C_AP1, 3'b010, 3'b000);   // D=M+1 -> 42
        rom16[2] = 16'd6;
        rom16[3] = ci(1'b0, C_DPA, 3'b001, 3'b000);   // M=D+A -> 48
        rom16[4] = 16'd4;
        rom16[5] = ci(1'b0, C_ZERO, 3'b000, 3'b111);
        dmem_rdy = 1'b0;
        w0 = wr_cnt;
        release_reset("r4");
        repeat (5) tick();
        chk("r4_load_req", dmem_req, 1);
        chk("r4_load_we", dmem_we, 0);
        chk("r4_load_addr", dmem_addr, 5);
        chk("r4_load_ireq", imem_req, 0);
        repeat (3) tick();
        chk("r4_wait_req", dmem_req, 1);
        chk("r4_wait_addr", dmem_addr, 5);
        dmem_rdy = 1'b1;
        wait_halt("r4", 100);
        chk("r4_wr_count", wr_cnt - w0, 1);
        chk("r4_wr_addr", w_addr, 6);
        chk("r4_wr_data", w_data, 48);
        chk("r4_retired", retired, 6);

        // ---- run 5: reset while a store is waiting ----
        hold_reset("r5");
        rom16[0] = 16'd3;
        rom16[1] = ci(1'b0, C_ONE, 3'b001, 3'b000);   // M=1
        dmem_rdy = 1'b0;
        release_reset("r5");
        repeat (5) tick();
        chk("r5_st_req", dmem_req, 1);
        chk("r5_st_we", dmem_we, 1);
        chk("r5_st_addr", dmem_addr, 3);
        chk("r5_st_wdata", dmem_wdata, 1);
        repeat (2) tick();
        chk("r5_st_hold", dmem_req, 1);
        w0 = wr_cnt;
        #2 rst16 = 1'b0;
        #1;
        chk("r5_async_dreq", dmem_req, 0);
        chk("r5_async_ireq", imem_req, 0);
        chk("r5_async_retired", retired, 0);
        tick();
        f0 = f_cnt;
        release_reset("r5");
        chk("r5_no_write", wr_cnt - w0, 0);
        tick();
        chk("r5_refetch_cnt", f_cnt - f0, 1);
        chk("r5_refetch_addr", f_hist[f0 % 64], 0);
        dmem_rdy = 1'b1;

        // ---- run 6: 32-bit data / 20-bit address build ----
        @(negedge clk);
        rst32 = 1'b1;
        begin
            int k;
            k = 0;
            while (f32_cnt < 8 && k < 100) begin
                tick();
                k++;
            end
        end
        begin
            logic [19:0] exp32 [0:7];
            exp32 = '{20'd0, 20'd1, 20'd2, 20'd3, 20'd4, 20'd5, 20'hFFFFF, 20'd0};
            chk("w32_fetch_count", f32_cnt, 8);
            for (int i = 0; i < 8; i++)
                chk($sformatf("w32_pc%0d", i), f32_hist[i], exp32[i]);
        end
        chk("w32_wr_count", w32_cnt, 1);
        chk("w32_wr_addr", w32_addr, 9);
        chk("w32_wr_data", w32_data, 64'h8000_0000);
        chk("w32_retired", retired32, 7);
        chk("w32_halted", halted32, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
